id_ex_pipe_reg: RTL and testbench

Parametrised decode-to-execute pipeline register for the 32-bit CPU. It replaces the unconditional one-cycle operand/control delay with a stage that has a valid bit, stall (hold), flush (bubble insert) and asynchronous reset. A write-back bypass keeps captured and held operands coherent with a same-cycle register-file write. A saturating counter reports consecutive stall cycles to the hazard unit.

---
 rtl/cpu_pipe_pkg.sv | 19 +
 rtl/id_ex_pipe_reg_if.sv | 46 ++++
 rtl/id_ex_pipe_reg_wb_bypass_sel.sv | 14 +
 rtl/id_ex_pipe_reg.sv | 56 +++++
 tb/tb_id_ex_pipe_reg.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared widths, bubble opcode and the id/ex stage bundle
package cpu_pipe_pkg;
  localparam int DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int OPCODE_W = 6;
  localparam logic [OPCODE_W-1:0] NOP_OPCODE = '0;
  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     reg_rs1;
    logic [DATA_W-1:0]     reg_rs2;
    logic [DATA_W-1:0]     immediate_value;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [OPCODE_W-1:0]   opcode;
    logic                  register_we;
    logic                  data_we;
  } id_ex_bundle;
endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: decode-side inputs, write-back bypass inputs and registered *_d1 outputs; master drives inputs, slave is the stage
interface id_ex_pipe_reg_if #(
  parameter int DATA_W = cpu_pipe_pkg::DATA_W,
  parameter int REG_ADDR_W = cpu_pipe_pkg::REG_ADDR_W,
  parameter int OPCODE_W = cpu_pipe_pkg::OPCODE_W,
  parameter int STALL_CNT_W = 4
);
  logic                   stall;
  logic                   flush;
  logic                   in_valid;
  logic [DATA_W-1:0]      reg_rs1;
  logic [DATA_W-1:0]      reg_rs2;
  logic [REG_ADDR_W-1:0]  rs1;
  logic [REG_ADDR_W-1:0]  rs2;
  logic [REG_ADDR_W-1:0]  rd;
  logic [DATA_W-1:0]      immediate_value_sign;
  logic [OPCODE_W-1:0]    opcode;
  logic                   register_we;
  logic                   data_we;
  logic                   wb_we;
  logic [REG_ADDR_W-1:0]  wb_rd;
  logic [DATA_W-1:0]      wb_data;
  logic [DATA_W-1:0]      reg_rs1_d1;
  logic [DATA_W-1:0]      reg_rs2_d1;
  logic [DATA_W-1:0]      immediate_value_d1;
  logic [REG_ADDR_W-1:0]  rs1_d1;
  logic [REG_ADDR_W-1:0]  rs2_d1;
  logic [REG_ADDR_W-1:0]  rd_d1;
  logic [OPCODE_W-1:0]    opcode_d1;
  logic                   register_we_d1;
  logic                   data_we_d1;
  logic                   valid_d1;
  logic [STALL_CNT_W-1:0] stall_cycles;
  modport master (
    output stall, flush, in_valid, reg_rs1, reg_rs2, rs1, rs2, rd, immediate_value_sign,
           opcode, register_we, data_we, wb_we, wb_rd, wb_data,
    input  reg_rs1_d1, reg_rs2_d1, immediate_value_d1, rs1_d1, rs2_d1, rd_d1, opcode_d1,
           register_we_d1, data_we_d1, valid_d1, stall_cycles
  );
  modport slave (
    input  stall, flush, in_valid, reg_rs1, reg_rs2, rs1, rs2, rd, immediate_value_sign,
           opcode, register_we, data_we, wb_we, wb_rd, wb_data,
    output reg_rs1_d1, reg_rs2_d1, immediate_value_d1, rs1_d1, rs2_d1, rd_d1, opcode_d1,
           register_we_d1, data_we_d1, valid_d1, stall_cycles
  );
endinterface

// File: rtl/id_ex_pipe_reg_wb_bypass_sel.sv
// wb_bypass_sel: picks wb_data over cand when write-back targets idx (never r0); ports idx, cand, wb_we, wb_rd, wb_data -> sel
module wb_bypass_sel import cpu_pipe_pkg::*; #(
  parameter int DATA_W = cpu_pipe_pkg::DATA_W,
  parameter int REG_ADDR_W = cpu_pipe_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0]     cand,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  output logic [DATA_W-1:0]     sel
);
  assign sel = (wb_we && wb_rd == idx && idx != '0) ? wb_data : cand;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: decode-to-execute register with valid/stall/flush, write-back bypass and saturating stall counter; ports clock, reset, bus (slave)
module id_ex_pipe_reg import cpu_pipe_pkg::*; #(
  parameter int DATA_W = cpu_pipe_pkg::DATA_W,
  parameter int REG_ADDR_W = cpu_pipe_pkg::REG_ADDR_W,
  parameter int OPCODE_W = cpu_pipe_pkg::OPCODE_W,
  parameter logic [OPCODE_W-1:0] NOP_OPCODE = cpu_pipe_pkg::NOP_OPCODE,
  parameter int STALL_CNT_W = 4,
  parameter bit MASK_R0_WE = 1'b1
) (
  input logic clock,
  input logic reset,
  id_ex_pipe_reg_if.slave bus
);
  logic [DATA_W-1:0] op1, op2;
  logic bubble;
  assign bubble = bus.flush || (!bus.stall && !bus.in_valid);
  wb_bypass_sel #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_byp1 (
    .idx(bus.stall ? bus.rs1_d1 : bus.rs1), .cand(bus.stall ? bus.reg_rs1_d1 : bus.reg_rs1),
    .wb_we(bus.wb_we), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data), .sel(op1)
  );
  wb_bypass_sel #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_byp2 (
    .idx(bus.stall ? bus.rs2_d1 : bus.rs2), .cand(bus.stall ? bus.reg_rs2_d1 : bus.reg_rs2),
    .wb_we(bus.wb_we), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data), .sel(op2)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset || bubble) begin
      bus.reg_rs1_d1 <= '0;
      bus.reg_rs2_d1 <= '0;
      bus.immediate_value_d1 <= '0;
      bus.rs1_d1 <= '0;
      bus.rs2_d1 <= '0;
      bus.rd_d1 <= '0;
      bus.opcode_d1 <= NOP_OPCODE;
      bus.register_we_d1 <= 1'b0;
      bus.data_we_d1 <= 1'b0;
      bus.valid_d1 <= 1'b0;
      bus.stall_cycles <= '0;
    end else if (bus.stall) begin
      bus.reg_rs1_d1 <= op1;
      bus.reg_rs2_d1 <= op2;
      bus.stall_cycles <= (bus.stall_cycles == '1) ? bus.stall_cycles : bus.stall_cycles + 1'b1;
    end else begin
      bus.reg_rs1_d1 <= op1;
      bus.reg_rs2_d1 <= op2;
      bus.immediate_value_d1 <= bus.immediate_value_sign;
      bus.rs1_d1 <= bus.rs1;
      bus.rs2_d1 <= bus.rs2;
      bus.rd_d1 <= bus.rd;
      bus.opcode_d1 <= bus.opcode;
      bus.register_we_d1 <= bus.register_we && (!MASK_R0_WE || bus.rd != '0);
      bus.data_we_d1 <= bus.data_we;
      bus.valid_d1 <= 1'b1;
      bus.stall_cycles <= '0;
    end
  end
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed and random stimulus against a bundle-level reference model of the id/ex stage
module tb_id_ex_pipe_reg;
  import cpu_pipe_pkg::*;
  logic clock = 1'b0;
  logic reset;
  int n_vec = 0;
  int n_err = 0;
  id_ex_bundle m;
  int unsigned cnt;
  id_ex_pipe_reg_if bus ();
  id_ex_pipe_reg dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m = '0;
    m.opcode = NOP_OPCODE;
    cnt = 0;
  endtask
  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] v);
    return (bus.wb_we && bus.wb_rd == idx && idx != 0) ? bus.wb_data : v;
  endfunction
  task automatic model_edge();
    if (bus.flush || (!bus.stall && !bus.in_valid)) model_reset();
    else if (bus.stall) begin
      if (m.valid) begin
        m.reg_rs1 = fwd(m.rs1, m.reg_rs1);
        m.reg_rs2 = fwd(m.rs2, m.reg_rs2);
      end
      cnt = (cnt < 15) ? cnt + 1 : 15;
    end else begin
      m.valid = 1'b1;
      m.reg_rs1 = fwd(bus.rs1, bus.reg_rs1);
      m.reg_rs2 = fwd(bus.rs2, bus.reg_rs2);
      m.immediate_value = bus.immediate_value_sign;
      m.rs1 = bus.rs1;
      m.rs2 = bus.rs2;
      m.rd = bus.rd;
      m.opcode = bus.opcode;
      m.register_we = bus.register_we && bus.rd != 0;
      m.data_we = bus.data_we;
      cnt = 0;
    end
  endtask
  task automatic check_all();
    chk("valid_d1", 32'(bus.valid_d1), 32'(m.valid));
    chk("reg_rs1_d1", bus.reg_rs1_d1, m.reg_rs1);
    chk("reg_rs2_d1", bus.reg_rs2_d1, m.reg_rs2);
    chk("imm_d1", bus.immediate_value_d1, m.immediate_value);
    chk("rs1_d1", 32'(bus.rs1_d1), 32'(m.rs1));
    chk("rs2_d1", 32'(bus.rs2_d1), 32'(m.rs2));
    chk("rd_d1", 32'(bus.rd_d1), 32'(m.rd));
    chk("opcode_d1", 32'(bus.opcode_d1), 32'(m.opcode));
    chk("register_we_d1", 32'(bus.register_we_d1), 32'(m.register_we));
    chk("data_we_d1", 32'(bus.data_we_d1), 32'(m.data_we));
    chk("stall_cycles", 32'(bus.stall_cycles), cnt);
  endtask
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask
  task automatic rnd_inputs();
    bus.in_valid = ($urandom_range(0, 9) != 0);
    bus.reg_rs1 = $urandom;
    bus.reg_rs2 = $urandom;
    bus.rs1 = 5'($urandom_range(0, 3));
    bus.rs2 = 5'($urandom_range(0, 3));
    bus.rd = 5'($urandom_range(0, 31));
    bus.immediate_value_sign = $urandom;
    bus.opcode = 6'($urandom);
    bus.register_we = 1'($urandom);
    bus.data_we = 1'($urandom);
    bus.wb_we = 1'($urandom);
    bus.wb_rd = 5'($urandom_range(0, 3));
    bus.wb_data = $urandom;
  endtask
  task automatic clear_inputs();
    {bus.stall, bus.flush, bus.in_valid, bus.register_we, bus.data_we, bus.wb_we} = '0;
    {bus.reg_rs1, bus.reg_rs2, bus.immediate_value_sign, bus.wb_data} = '0;
    {bus.rs1, bus.rs2, bus.rd, bus.wb_rd, bus.opcode} = '0;
  endtask
  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    #2;
    check_all();
    #1 reset = 1'b0;
    bus.in_valid = 1;
    bus.reg_rs1 = 32'h1111_0000;
    bus.rs1 = 3;
    bus.rd = 7;
    bus.register_we = 1;
    bus.opcode = 6'h11;
    step();
    chk("load_rs1_val", bus.reg_rs1_d1, 32'h1111_0000);
    chk("load_rd", 32'(bus.rd_d1), 32'd7);
    chk("load_we", 32'(bus.register_we_d1), 32'd1);
    bus.stall = 1;
    for (int i = 0; i < 20; i++) begin
      rnd_inputs();
      bus.wb_we = 0;
      step();
    end
    chk("stall_sat", 32'(bus.stall_cycles), 32'd15);
    chk("stall_hold_rs1", bus.reg_rs1_d1, 32'h1111_0000);
    clear_inputs();
    bus.in_valid = 1;
    bus.data_we = 1;
    bus.opcode = 6'h2a;
    step();
    chk("stall_release", 32'(bus.stall_cycles), 32'd0);
    bus.stall = 1;
    bus.flush = 1;
    step();
    chk("flush_valid", 32'(bus.valid_d1), 32'd0);
    chk("flush_opcode", 32'(bus.opcode_d1), 32'(NOP_OPCODE));
    clear_inputs();
    bus.in_valid = 1;
    bus.rs1 = 5;
    bus.rs2 = 5;
    bus.reg_rs1 = 32'h1234_5678;
    bus.reg_rs2 = 32'h8765_4321;
    bus.wb_we = 1;
    bus.wb_rd = 5;
    bus.wb_data = 32'hDEAD_BEEF;
    step();
    chk("cap_byp1", bus.reg_rs1_d1, 32'hDEAD_BEEF);
    chk("cap_byp2", bus.reg_rs2_d1, 32'hDEAD_BEEF);
    bus.rs1 = 0;
    bus.wb_rd = 0;
    step();
    chk("cap_r0", bus.reg_rs1_d1, 32'h1234_5678);
    bus.rs1 = 4;
    bus.rs2 = 9;
    bus.wb_we = 0;
    step();
    bus.stall = 1;
    bus.wb_we = 1;
    bus.wb_rd = 9;
    bus.wb_data = 32'h0000_00AA;
    bus.reg_rs2 = 32'h5555_5555;
    step();
    chk("hold_byp2", bus.reg_rs2_d1, 32'h0000_00AA);
    chk("hold_rs1", bus.reg_rs1_d1, 32'h1234_5678);
    clear_inputs();
    bus.in_valid = 1;
    bus.rd = 0;
    bus.register_we = 1;
    step();
    chk("r0_mask", 32'(bus.register_we_d1), 32'd0);
    for (int i = 0; i < 500; i++) begin
      rnd_inputs();
      bus.stall = ($urandom_range(0, 9) < 4);
      bus.flush = ($urandom_range(0, 15) == 0);
      step();
    end
    clear_inputs();
    bus.in_valid = 1;
    bus.opcode = 6'h23;
    bus.rd = 3;
    bus.register_we = 1;
    bus.reg_rs1 = 32'hCAFE_0001;
    step();
    bus.stall = 1;
    step();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_all();
    #2 reset = 1'b0;
    bus.stall = 0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
